// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 PIPE pipeline control: stall/bubble generation for F/D/E/M/W, a one-cycle
// post-reset flush, a sticky halt on exception, and saturating hazard counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             W_bubble,
  output logic             halted,
  output logic [2:0]       halt_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [1:0] ST_FLUSH  = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic is_exc(input logic [2:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    if (en && (c != CNT_MAX)) return c + CNT_ONE;
    return c;
  endfunction

  logic [1:0] state;
  logic       lu;
  logic       ret;
  logic       mp;

  assign lu  = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mp  = (E_icode == IJXX) && !e_Cnd;

  assign halted = (state == ST_HALTED);

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    case (state)
      ST_RUN: begin
        F_stall  = lu || ret;
        D_stall  = lu;
        D_bubble = mp || (ret && !lu);
        E_bubble = mp || lu;
        M_bubble = is_exc(m_stat) || is_exc(W_stat);
        W_stall  = is_exc(W_stat);
      end
      ST_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      default: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FLUSH;
      halt_stat <= 3'd0;
      cyc_cnt   <= '0;
      lu_cnt    <= '0;
      mp_cnt    <= '0;
      ret_cnt   <= '0;
    end else begin
      case (state)
        ST_FLUSH: state <= ST_RUN;
        ST_RUN: begin
          cyc_cnt <= sat_inc(cyc_cnt, 1'b1);
          lu_cnt  <= sat_inc(lu_cnt, lu);
          mp_cnt  <= sat_inc(mp_cnt, mp);
          ret_cnt <= sat_inc(ret_cnt, ret && !lu);
          if (is_exc(W_stat)) begin
            state     <= ST_HALTED;
            halt_stat <= W_stat;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic e_Cnd;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, halted;
  logic [2:0] halt_stat;
  logic [CNT_W-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .W_bubble(W_bubble), .halted(halted), .halt_stat(halt_stat), .cyc_cnt(cyc_cnt),
    .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]       ctl;
    logic             hl;
    logic [2:0]       hs;
    logic [CNT_W-1:0] c, l, m, r;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] ec, el, em, er;
  logic             eh;
  logic [2:0]       ehs;

  // ctl order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble}
  localparam logic [6:0] C_FLUSH = 7'b1011101;
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1101000;
  localparam logic [6:0] C_MP    = 7'b0011000;
  localparam logic [6:0] C_RET   = 7'b1010000;
  localparam logic [6:0] C_HALT  = 7'b1101110;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
    if (en && v != {CNT_W{1'b1}}) return v + 1'b1;
    return v;
  endfunction

  // Drive one cycle's inputs and queue what the DUT must show during that cycle.
  task automatic cyc(input logic [3:0] di, sa, sb, ei, edm, input logic cnd,
                     input logic [3:0] mi, input logic [2:0] ms, ws,
                     input logic [6:0] ctl, input logic ic, il, im, ir,
                     input logic go_halt);
    exp_t e;
    D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = edm;
    e_Cnd = cnd; M_icode = mi; m_stat = ms; W_stat = ws;
    e.ctl = ctl; e.hl = eh; e.hs = ehs; e.c = ec; e.l = el; e.m = em; e.r = er;
    exp_q.push_back(e);
    ec = bump(ec, ic); el = bump(el, il); em = bump(em, im); er = bump(er, ir);
    if (go_halt) begin eh = 1'b1; ehs = ws; end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [6:0] ctl, input logic ic);
    cyc(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, ctl, ic, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
    e_Cnd = 1'b1; M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ec = '0; el = '0; em = '0; er = '0; eh = 1'b0; ehs = 3'd0;
    idle(C_FLUSH, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble} != e.ctl) begin
        n_fail++;
        $display("FAIL ctl t=%0t got %b want %b", $time,
                 {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble}, e.ctl);
      end
      n_checks++;
      if (halted !== e.hl || halt_stat !== e.hs) begin
        n_fail++;
        $display("FAIL halt t=%0t got %b/%0d want %b/%0d", $time, halted, halt_stat, e.hl, e.hs);
      end
      n_checks++;
      if ({cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== {e.c, e.l, e.m, e.r}) begin
        n_fail++;
        $display("FAIL cnt t=%0t got c%0d l%0d m%0d r%0d want c%0d l%0d m%0d r%0d", $time,
                 cyc_cnt, lu_cnt, mp_cnt, ret_cnt, e.c, e.l, e.m, e.r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, flush, then idle RUN cycles
    do_reset();
    repeat (4) idle(C_NONE, 1'b1);

    // Load/use, then a non-matching RNONE pair
    do_reset();
    cyc(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, C_LU, 1, 1, 0, 0, 0);
    cyc(4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, C_NONE, 1, 0, 0, 0, 0);
    cyc(4'h1, 4'h2, 4'h7, 4'hB, 4'h7, 1'b1, 4'h1, 3'd1, 3'd1, C_LU, 1, 1, 0, 0, 0);
    idle(C_NONE, 1'b1);

    // Mispredict, then taken jump
    do_reset();
    cyc(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, C_MP, 1, 0, 1, 0, 0);
    cyc(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, C_NONE, 1, 0, 0, 0, 0);
    idle(C_NONE, 1'b1);

    // Ret walking D->E->M, then lu+ret, then mp+ret
    do_reset();
    cyc(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, C_RET, 1, 0, 0, 1, 0);
    cyc(4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, C_RET, 1, 0, 0, 1, 0);
    cyc(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 3'd1, 3'd1, C_RET, 1, 0, 0, 1, 0);
    cyc(4'h9, 4'h4, 4'hF, 4'hB, 4'h4, 1'b1, 4'h1, 3'd1, 3'd1, C_LU, 1, 1, 0, 0, 0);
    cyc(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 7'b1011000, 1, 0, 1, 1, 0);
    idle(C_NONE, 1'b1);

    // Exceptions: m_stat alone, with lu, non-exception codes, then W_stat halts
    do_reset();
    cyc(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1, 7'b0000100, 1, 0, 0, 0, 0);
    cyc(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd4, 3'd1, 7'b1101100, 1, 1, 0, 0, 0);
    cyc(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd5, 3'd0, C_NONE, 1, 0, 0, 0, 0);
    cyc(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd3, 7'b0000110, 1, 0, 0, 0, 1);
    cyc(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd3, C_HALT, 0, 0, 0, 0, 0);
    cyc(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h1, 3'd1, 3'd1, C_HALT, 0, 0, 0, 0, 0);
    idle(C_HALT, 1'b0);
    do_reset();
    idle(C_NONE, 1'b1);

    // Saturation with 4-bit counters
    do_reset();
    repeat (20) idle(C_NONE, 1'b1);
    idle(C_NONE, 1'b1);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue has %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the Y86-64 PIPE processor.
- Generates stall and bubble controls for the F, D, E, M and W pipeline registers. Conditions covered: load/use hazards, mispredicted jumps, ret, and exceptions.
- Adds a post-reset flush state and a sticky halted state that freezes the pipeline.
- Keeps saturating performance counters for cycles and each hazard class.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
D_icode  input  4  icode in D register
d_srcA  input  4  decode-stage srcA
d_srcB  input  4  decode-stage srcB
E_icode  input  4  icode in E register
E_dstM  input  4  dstM in E register
e_Cnd  input  1  execute-stage condition result
M_icode  input  4  icode in M register
m_stat  input  3  memory-stage status
W_stat  input  3  status in W register
F_stall  output  1  hold F register
D_stall  output  1  hold D register
D_bubble  output  1  load nop into D
E_bubble  output  1  load nop into E
M_bubble  output  1  load nop into M
W_stall  output  1  hold W register
W_bubble  output  1  load nop into W (flush only)
halted  output  1  pipeline frozen by exception
halt_stat  output  3  W_stat captured at halt
cyc_cnt  output  CNT_W  RUN cycles
lu_cnt  output  CNT_W  load/use stall cycles
mp_cnt  output  CNT_W  mispredict cycles
ret_cnt  output  CNT_W  ret bubble cycles

Behaviour:

Encodings:
- icode: IJXX=7, IRET=9, IMRMOVQ=5, IPOPQ=0xB.
- RNONE=0xF.
- stat: SAOK=1, SHLT=2, SADR=3, SINS=4. "exc(s)" means s is in {2,3,4}.

Reset:
- rst_n sampled low at an edge: state<=FLUSH, halted<=0, halt_stat<=0, all counters<=0.
- Reset overrides every other event, including reset while in HALTED.

States: FLUSH, RUN, HALTED.
- Control outputs decode combinationally from state and inputs.
- Counters, halted and halt_stat are registered.

FLUSH:
- Outputs: F_stall=1; D_bubble=E_bubble=M_bubble=W_bubble=1; all other controls 0.
- Lasts exactly 1 cycle, then goes to RUN.
- Counters hold.

RUN, internal terms:
- lu = E_icode in {5,0xB} && E_dstM!=0xF && (E_dstM==d_srcA || E_dstM==d_srcB)
- ret = IRET in {D_icode, E_icode, M_icode}
- mp = E_icode==7 && !e_Cnd

RUN, outputs:
- F_stall = lu || ret
- D_stall = lu
- D_bubble = mp || (ret && !lu)
- E_bubble = mp || lu
- M_bubble = exc(m_stat) || exc(W_stat)
- W_stall = exc(W_stat)
- W_bubble = 0
- D_stall and D_bubble are never both 1.

RUN, counters (saturating at 2^CNT_W-1, never wrap):
- cyc_cnt +1 every RUN cycle.
- lu_cnt +1 if lu.
- mp_cnt +1 if mp.
- ret_cnt +1 if ret && !lu.

RUN -> HALTED:
- Trigger: exc(W_stat) in RUN.
- At the next edge: halted<=1, halt_stat<=W_stat.
- The transition cycle itself still uses RUN outputs and counts.

HALTED:
- Outputs: F_stall=D_stall=W_stall=1; E_bubble=M_bubble=1; D_bubble=W_bubble=0.
- Counters frozen.
- Stays in HALTED regardless of input changes; only rst_n exits, to FLUSH.

Simultaneous events:
- mp together with ret in D: F_stall=1, D_bubble=1, E_bubble=1.
- lu together with ret: stall wins, so D_stall=1 and D_bubble=0.
- exc(m_stat) together with lu or mp: both control sets apply independently.

Status value 0 or values 5..7 are treated as non-exception.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 for 2 edges, release.
   - Response: next cycle F_stall=1, D/E/M/W_bubble=1. Following cycle with idle inputs (all icode=1, stat=1): all controls 0. After 3 RUN cycles cyc_cnt=3, other counters 0.
2. Load/use:
   - Stimulus: E_icode=5, E_dstM=3, d_srcA=3.
   - Response: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt increments by 1.
   - Stimulus: E_dstM=0xF, d_srcA=0xF.
   - Response: no stall.
3. Mispredict:
   - Stimulus: E_icode=7, e_Cnd=0.
   - Response: D_bubble=1, E_bubble=1, F_stall=0, mp_cnt=1.
   - Stimulus: e_Cnd=1.
   - Response: all controls 0.
4. Ret:
   - Stimulus: IRET walks D→E→M over 3 cycles.
   - Response: F_stall=1, D_bubble=1 each cycle; ret_cnt=3.
   - Stimulus: D_icode=9, d_srcA=4, E_icode=0xB, E_dstM=4.
   - Response: D_stall=1, D_bubble=0, E_bubble=1.
5. Exception:
   - Stimulus: m_stat=3.
   - Response: M_bubble=1.
   - Stimulus: next cycle W_stat=3.
   - Response: W_stall=1, M_bubble=1; next edge halted=1, halt_stat=3, counters frozen.
   - Stimulus: W_stat=1.
   - Response: still halted.
   - Stimulus: rst_n=0.
   - Response: FLUSH, halted=0.
6. Saturation:
   - Stimulus: CNT_W=4, 20 RUN cycles.
   - Response: cyc_cnt=15 and holds; no wrap to 0.
